motion_sensing: RTL and testbench

MOTION_SENSING -- requirements
Module: motion_sensing

---
 rtl/motion_sensing_if.sv | 19 +
 rtl/motion_sensing.sv | 98 +++++++++
 tb/tb_motion_sensing.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/motion_sensing_if.sv
// Lamp-control bus: raw sensor/switch inputs towards the controller and the
// registered lamp enable back out.
interface motion_sensing_if;
    logic motion_sensor;
    logic manual_override;
    logic lights_on;

    modport master (
        output motion_sensor,
        output manual_override,
        input  lights_on
    );

    modport slave (
        input  motion_sensor,
        input  manual_override,
        output lights_on
    );
endinterface

// File: rtl/motion_sensing.sv
// Motion-activated lighting controller.
// Both raw inputs are asynchronous and are brought into clk through 2-flop
// synchronizers. The FSM keeps the lights on while motion is present and for
// HOLD_CYCLES clocks after it goes away. The manual override is ORed in at
// the output flop so the FSM keeps tracking motion underneath it.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | lights off (unless overridden), no motion seen
// ACTIVE | synchronized motion present
// HOLD   | motion gone, counter running down before returning to IDLE
module motion_sensing #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    motion_sensing_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Loading HOLD_CYCLES-1 makes the terminal-count edge itself one of the
    // hold cycles, so the lights stay on for exactly HOLD_CYCLES edges.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic             m_s1;
    logic             m_s2;
    logic             o_s1;
    logic             o_s2;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic             lights_q;

    assign bus.lights_on = lights_q;

    // Two-stage synchronizers for the asynchronous sensor and switch.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_s1 <= 1'b0;
            m_s2 <= 1'b0;
            o_s1 <= 1'b0;
            o_s2 <= 1'b0;
        end else begin
            m_s1 <= bus.motion_sensor;
            m_s2 <= m_s1;
            o_s1 <= bus.manual_override;
            o_s2 <= o_s1;
        end
    end

    // Next-state decision; the output flop needs it to stay in step with state.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (m_s2) next_state = ACTIVE;
            end
            ACTIVE: begin
                if (!m_s2) next_state = HOLD;
            end
            HOLD: begin
                if (m_s2)             next_state = ACTIVE;
                else if (count == '0) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State, hold counter and registered lamp enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            lights_q <= 1'b0;
        end else begin
            state    <= next_state;
            lights_q <= (next_state != IDLE) | o_s2;
            case (state)
                ACTIVE: begin
                    if (!m_s2) count <= HOLD_LOAD;
                end
                HOLD: begin
                    // Retrigger leaves the count alone; it is reloaded on the
                    // next ACTIVE->HOLD transition anyway.
                    if (!m_s2 && count != '0) count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_motion_sensing.sv
// Bench for motion_sensing with HOLD_CYCLES=4.
// Reference model: lights after edge e are on if a motion sample lies in the
// window [e-2-H, e-2], or override was sampled at e-2, with no reset edge
// between that sample and e. A reset edge itself forces lights off.
module tb_motion_sensing;

    localparam int H    = 4;
    localparam int MAXE = 2048;

    logic clk = 1'b0;
    logic reset;

    motion_sensing_if tbif ();

    motion_sensing #(.HOLD_CYCLES(H), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tbif.slave)
    );

    always #5 clk = ~clk;

    bit m_h [0:MAXE-1];
    bit o_h [0:MAXE-1];
    bit r_h [0:MAXE-1];
    int n_edge = 0;
    int n_vec  = 0;
    int n_err  = 0;
    logic exp_l;

    function automatic logic model(input int e);
        logic lit;
        lit = 1'b0;
        if (r_h[e]) return 1'b0;
        for (int j = e - 1; j >= e - 2 - H && j >= 1; j--) begin
            if (r_h[j]) break;
            if (j <= e - 2 && m_h[j]) lit = 1'b1;
            if (j == e - 2 && o_h[j]) lit = 1'b1;
        end
        return lit;
    endfunction

    // Drive one cycle of inputs, record what the edge samples, and update
    // the expected output.
    task automatic step(input bit m, input bit o, input bit r);
        tbif.motion_sensor   = m;
        tbif.manual_override = o;
        reset                = r;
        @(posedge clk);
        if (n_edge < MAXE - 1) n_edge++;
        m_h[n_edge] = m;
        o_h[n_edge] = o;
        r_h[n_edge] = r;
        #1;
        exp_l = model(n_edge);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1);
            n_vec++;
            if (tbif.lights_on !== 1'b0) begin
                n_err++;
                $display("FAIL reset_all_inputs edge %0d: lights_on=%b required 0", n_edge, tbif.lights_on);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_vec++;
            if (tbif.lights_on !== exp_l) begin
                n_err++;
                $display("FAIL reset_release edge %0d: lights_on=%b required %b", n_edge, tbif.lights_on, exp_l);
            end
        end
    endtask

    // Motion high for two edges: on for 6 edges (N+2..N+7).
    task automatic test_hold();
        int ones = 0;
        for (int i = 0; i < 14; i++) begin
            step(i < 2, 1'b0, 1'b0);
            if (tbif.lights_on === 1'b1) ones++;
            n_vec++;
            if (tbif.lights_on !== exp_l) begin
                n_err++;
                $display("FAIL hold edge %0d: lights_on=%b required %b", n_edge, tbif.lights_on, exp_l);
            end
        end
        n_vec++;
        if (ones !== H + 2) begin
            n_err++;
            $display("FAIL hold_length: on for %0d edges, required %0d", ones, H + 2);
        end
    endtask

    // Single-cycle pulse: on for N+2..N+6, off after N+7.
    task automatic test_pulse();
        int ones = 0;
        for (int i = 0; i < 12; i++) begin
            step(i == 0, 1'b0, 1'b0);
            if (tbif.lights_on === 1'b1) ones++;
            n_vec++;
            if (tbif.lights_on !== exp_l) begin
                n_err++;
                $display("FAIL pulse edge %0d: lights_on=%b required %b", n_edge, tbif.lights_on, exp_l);
            end
        end
        n_vec++;
        if (ones !== H + 1) begin
            n_err++;
            $display("FAIL pulse_length: on for %0d edges, required %0d", ones, H + 1);
        end
    endtask

    // Motion returns during HOLD: lights never drop, hold restarts.
    task automatic test_retrigger();
        bit pat [0:19];
        int ones = 0;
        for (int i = 0; i < 20; i++) pat[i] = (i < 2) || (i == 4) || (i == 5);
        for (int i = 0; i < 20; i++) begin
            step(pat[i], 1'b0, 1'b0);
            if (tbif.lights_on === 1'b1) ones++;
            n_vec++;
            if (tbif.lights_on !== exp_l) begin
                n_err++;
                $display("FAIL retrigger edge %0d: lights_on=%b required %b", n_edge, tbif.lights_on, exp_l);
            end
        end
        n_vec++;
        if (ones !== 6 + H) begin
            n_err++;
            $display("FAIL retrigger_length: on for %0d edges, required %0d", ones, 6 + H);
        end
    endtask

    // Override high for 5 edges with no motion: on O+2..O+6.
    task automatic test_override();
        int ones = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, i < 5, 1'b0);
            if (tbif.lights_on === 1'b1) ones++;
            n_vec++;
            if (tbif.lights_on !== exp_l) begin
                n_err++;
                $display("FAIL override edge %0d: lights_on=%b required %b", n_edge, tbif.lights_on, exp_l);
            end
        end
        n_vec++;
        if (ones !== 5) begin
            n_err++;
            $display("FAIL override_length: on for %0d edges, required 5", ones);
        end
    endtask

    // Reset while in HOLD with override active, then quiet inputs.
    task automatic test_reset_mid_hold();
        for (int i = 0; i < 7; i++) step(i < 2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        n_vec++;
        if (tbif.lights_on !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_hold edge %0d: lights_on=%b required 0", n_edge, tbif.lights_on);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_vec++;
            if (tbif.lights_on !== 1'b0) begin
                n_err++;
                $display("FAIL after_reset_quiet edge %0d: lights_on=%b required 0", n_edge, tbif.lights_on);
            end
        end
    endtask

    // Bursty random motion/override with occasional resets.
    task automatic test_random();
        bit m = 1'b0;
        bit o = 1'b0;
        bit r;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 5) == 0) m = ~m;
            if ($urandom_range(0, 15) == 0) o = ~o;
            r = ($urandom_range(0, 60) == 0);
            step(m, o, r);
            n_vec++;
            if (tbif.lights_on !== exp_l) begin
                n_err++;
                $display("FAIL random edge %0d: lights_on=%b required %b (m=%b o=%b r=%b)",
                         n_edge, tbif.lights_on, exp_l, m, o, r);
            end
        end
    endtask

    initial begin
        tbif.motion_sensor   = 1'b0;
        tbif.manual_override = 1'b0;
        reset                = 1'b1;
        test_reset();
        test_hold();
        test_pulse();
        test_retrigger();
        test_override();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
